// File: rtl/response_monitor_pkg.sv
// rtl/response_monitor_pkg.sv - shared defaults, record layout and FSM states for response_monitor
package response_monitor_pkg;

   localparam int TS_W_DEF  = 16;
   localparam int DEPTH_DEF = 4;
   localparam int CNT_W_DEF = 8;
   localparam int STIM_W    = 3;

   typedef struct packed {
      logic [TS_W_DEF-1:0] ts;
      logic [STIM_W-1:0]   stim;
      logic                obs;
   } rec_t;

   // Bits of a record below the timestamp field (stim + obs).
   localparam int REC_TAIL_W = $bits(rec_t) - TS_W_DEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/rm_fifo.sv
// rtl/rm_fifo.sv - synchronous first-word fall-through FIFO for event records
module rm_fifo #(
   parameter int W     = 20,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
   assign do_push = push_i && (!full_o || do_pop);
   // Storage is not reset; gating the head keeps rd_data at zero while empty.
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/response_monitor.sv
// rtl/response_monitor.sv - timestamps stimulus/response changes into a FIFO and counts compare errors
module response_monitor
   import response_monitor_pkg::*;
#(
   parameter int TS_W  = TS_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [STIM_W-1:0] stim,
   input  logic              obs,
   input  logic              exp_valid,
   input  logic              exp,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [TS_W+3:0]   rd_data,
   output logic              mismatch,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              ovf,
   output logic [CNT_W-1:0]  ovf_cnt
);

   localparam int REC_W = TS_W + REC_TAIL_W;

   state_e                  state_q, state_d;
   logic [TS_W-1:0]         ts_q, ts_d;
   logic [REC_TAIL_W-1:0]   prev_q, prev_d;
   logic                    mismatch_q, mismatch_d;
   logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;
   logic                    ovf_q, ovf_d;
   logic [CNT_W-1:0]        ovf_cnt_q, ovf_cnt_d;

   logic [REC_TAIL_W-1:0]   cur;
   logic                    ev;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    drop;
   logic                    miscmp;
   logic [REC_W-1:0]        push_rec;

   assign cur      = {stim, obs};
   assign push_rec = {ts_q, cur};
   assign rd_valid = !fifo_empty;
   // A full FIFO with no pop this cycle cannot take the event.
   assign drop     = ev && fifo_full && !rd_ready;
   assign miscmp   = exp_valid && (obs != exp);

   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      ev      = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) state_d = ARM;
         end
         ARM: begin
            prev_d  = cur;
            state_d = RUN;
         end
         RUN: begin
            if (cur != prev_q) begin
               ev     = 1'b1;
               prev_d = cur;
            end
            if (!en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ts_d       = ts_q + TS_W'(1);
      mismatch_d = miscmp;
      err_cnt_d  = err_cnt_q;
      ovf_d      = ovf_q;
      ovf_cnt_d  = ovf_cnt_q;
      if (miscmp && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (drop) begin
         ovf_d = 1'b1;
         if (ovf_cnt_q != {CNT_W{1'b1}}) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         ts_q       <= '0;
         prev_q     <= '0;
         mismatch_q <= 1'b0;
         err_cnt_q  <= '0;
         ovf_q      <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         ts_q       <= ts_d;
         prev_q     <= prev_d;
         mismatch_q <= mismatch_d;
         err_cnt_q  <= err_cnt_d;
         ovf_q      <= ovf_d;
         ovf_cnt_q  <= ovf_cnt_d;
      end
   end

   assign mismatch = mismatch_q;
   assign err_cnt  = err_cnt_q;
   assign ovf      = ovf_q;
   assign ovf_cnt  = ovf_cnt_q;

   rm_fifo #(
      .W     (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (ev),
      .push_data_i (push_rec),
      .pop_i       (rd_ready),
      .head_o      (rd_data),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

endmodule

// File: doc/response_monitor.md
RESPONSE_MONITOR -- requirements
Module: response_monitor

Interface
REQ-001 Parameter TS_W, default 16, timestamp width in bits.
REQ-002 Parameter DEPTH, default 4, event FIFO depth; power of two, at least 2.
REQ-003 Parameter CNT_W, default 8, width of the error and overflow counters.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  capture enable.
REQ-007 stim  input  3  stimulus vector applied to the DUT (A,B,C).
REQ-008 obs  input  1  DUT response (OUT).
REQ-009 exp_valid  input  1  expected-value strobe.
REQ-010 exp  input  1  expected value of obs, compared in the exp_valid cycle.
REQ-011 rd_ready  input  1  reader accepts the head record.
REQ-012 rd_valid  output  1  FIFO not empty.
REQ-013 rd_data  output  TS_W+4  head record {ts, stim, obs}.
REQ-014 mismatch  output  1  one-cycle pulse on a compare failure.
REQ-015 err_cnt  output  CNT_W  saturating mismatch count.
REQ-016 ovf  output  1  sticky flag: an event was dropped.
REQ-017 ovf_cnt  output  CNT_W  saturating count of dropped events.

Function
REQ-018 Timestamp counter ts shall increment every cycle, independent of en.
REQ-019 ts shall wrap from 2^TS_W-1 to 0.
REQ-020 FSM states and transitions:
- IDLE: en=1 goes to ARM.
- ARM: lasts exactly one cycle; loads prev <= {stim,obs} without generating an event; then goes to RUN.
- RUN: en=0 goes to IDLE.
REQ-021 In RUN, an event shall be raised in any cycle where {stim,obs} != prev; prev shall update to the new {stim,obs} in the same cycle.
REQ-022 An event shall push {ts, stim, obs} into the FIFO, using the ts value of the detecting cycle.
REQ-023 Event-to-rd_valid latency when the FIFO is empty shall be 1 cycle.
REQ-024 A pop shall occur when rd_valid and rd_ready are both 1; rd_data shall be stable while rd_valid=1 and rd_ready=0.
REQ-025 Overflow handling:
- A push to a full FIFO shall be dropped, set ovf, and increment ovf_cnt.
- Exception: a push in the same cycle as a pop from a full FIFO shall be accepted.
REQ-026 Simultaneous push and pop on an empty FIFO shall write the FIFO; rd_valid shall assert the next cycle.
REQ-027 With exp_valid=1, obs != exp shall assert mismatch the next cycle and increment err_cnt.
REQ-028 The comparison in REQ-027 shall operate in every FSM state.
REQ-029 err_cnt and ovf_cnt shall saturate at 2^CNT_W-1.
REQ-030 Dropping en mid-RUN shall not flush the FIFO; already-queued records remain readable.

Reset
REQ-031 reset shall take priority over every other input.
REQ-032 On reset, all of the following shall clear: ts=0, state=IDLE, prev=0, FIFO empty, rd_valid=0, mismatch=0, err_cnt=0, ovf=0, ovf_cnt=0.
REQ-033 rd_data shall read 0 after reset.
REQ-034 Reset asserted mid-operation shall discard queued records within one cycle.

Structure
REQ-035 Package response_monitor_pkg shall hold:
- default TS_W, DEPTH, CNT_W;
- the record struct {ts, stim, obs};
- the state enum {IDLE, ARM, RUN}.
REQ-036 The FIFO shall be a sub-module rm_fifo (synchronous, first-word fall-through, full/empty outputs), instantiated once.

Verification
REQ-037 Baseline and two events (rd_ready=1 throughout):
- Reset, then en=1 at ts=2; drive stim=000/obs=0.
- At ts=10 drive 111/obs=0; at ts=15 obs=1.
- Expect exactly 2 records: {10,111,0} then {15,111,1}; no record at ts=3.
REQ-038 Overflow (DEPTH=4, rd_ready=0):
- Generate 6 changes on consecutive cycles.
- Expect 4 records held, ovf=1, ovf_cnt=2.
- Then raise rd_ready and expect the first 4 records in order.
REQ-039 Full FIFO, simultaneous push and pop:
- Expect the record accepted, ovf stays 0, occupancy stays 4.
REQ-040 Checker:
- exp_valid=1, exp=1, obs=0 on 3 cycles: mismatch pulses 3 times, err_cnt=3.
- exp=obs: no pulse.
- Force 300 mismatches with CNT_W=8: err_cnt=255.
REQ-041 Timestamp wrap (TS_W=4):
- Generate an event at ts=15 and another 2 cycles later.
- Expect record timestamps 15 then 1.
REQ-042 Reset mid-operation:
- Assert reset with 3 records queued.
- Next cycle: rd_valid=0, ts=0, state=IDLE; a change in the following cycle produces no record until ARM completes.
